// File: rtl/inst_mem_arbiter_pkg.sv
// Shared instruction-memory definitions: bus widths, ROM depth,
// chip-enable levels and the arbiter port enum used for priority.
package inst_mem_arbiter_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    // log2 of ROM depth in words; shared with the ROM model
    localparam int MEM_LOG2    = 17;

    typedef logic [INST_ADDR_W-1:0] InstAddrBus;
    typedef logic [INST_W-1:0]      InstBus;

    localparam InstBus ZeroWord    = '0;
    localparam logic   ChipEnable  = 1'b1;
    localparam logic   ChipDisable = 1'b0;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_IF) ? PORT_LS : PORT_IF;
    endfunction

endpackage

// File: rtl/inst_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a single priority flop.
// Ports: clk, rst (async high), i_req[1:0] (0=IF,1=LS), o_gnt[1:0].
module rr_arb2
    import inst_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    port_e      r_prio;
    logic [1:0] w_gnt;

    // Grants are forced low while reset is asserted, so nothing
    // reaches the ROM even if requesters keep their lines high.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            unique case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_prio == PORT_IF) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    // The port just served drops to low priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= PORT_IF;
        end else if (w_gnt[0]) begin
            r_prio <= other_port(PORT_IF);
        end else if (w_gnt[1]) begin
            r_prio <= other_port(PORT_LS);
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares the instruction ROM read port between fetch (IF) and load (LS).
// Ports: IF/LS req/addr/gnt/rvalid/rdata/err, ROM ce/addr/inst, stallreq.
module inst_mem_arbiter
    import inst_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = INST_ADDR_W,
    parameter int DATA_W   = INST_W,
    parameter int MEM_LOG2 = inst_mem_arbiter_pkg::MEM_LOG2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,

    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,

    output logic              stallreq
);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_any;
    logic [ADDR_W-1:0] w_addr;
    logic              w_oor;
    logic              w_mis;
    logic              w_bad;
    logic              w_ok;

    logic              r_if_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_err;
    logic              r_ls_rvalid;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_ls_err;

    // A flushed fetch is not eligible, leaving the slot to LS.
    assign w_req = {ls_req, if_req & ~if_flush};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign w_any  = |w_gnt;
    assign w_addr = w_gnt[1] ? ls_addr : if_addr;

    // Any bit above the word-index range means the address is past the ROM.
    assign w_oor  = |w_addr[ADDR_W-1:MEM_LOG2+2];
    assign w_mis  = |w_addr[1:0];
    assign w_bad  = w_oor | w_mis;
    assign w_ok   = w_any & ~w_bad;

    assign rom_ce   = w_ok ? ChipEnable : ChipDisable;
    assign rom_addr = w_ok ? w_addr : '0;

    assign if_gnt   = w_gnt[0];
    assign ls_gnt   = w_gnt[1];
    assign stallreq = if_req & ~w_gnt[0] & ~if_flush;

    // Only one port is granted per cycle, so rom_inst belongs to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
        end else begin
            r_if_rvalid <= w_gnt[0];
            r_if_rdata  <= (w_gnt[0] & ~w_bad) ? rom_inst : '0;
            r_if_err    <= w_gnt[0] & w_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ls_rvalid <= 1'b0;
            r_ls_rdata  <= '0;
            r_ls_err    <= 1'b0;
        end else begin
            r_ls_rvalid <= w_gnt[1];
            r_ls_rdata  <= (w_gnt[1] & ~w_bad) ? rom_inst : '0;
            r_ls_err    <= w_gnt[1] & w_bad;
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign ls_rvalid = r_ls_rvalid;
    assign ls_rdata  = r_ls_rdata;
    assign ls_err    = r_ls_err;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed testbench for inst_mem_arbiter: vector table plus
// hand-written contention, flush and mid-access reset sequences.
module tb_inst_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic [31:0] ls_addr;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        stallreq;

    int n_checks;
    int n_errors;

    inst_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_addr   (ls_addr),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_inst  (rom_inst),
        .stallreq  (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: word 1 holds the known instruction, others are address-tagged
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a[31:2] == 30'd1) return 32'h3401_0100;
        return 32'hA500_0000 | a;
    endfunction

    assign rom_inst = rom_word(rom_addr);

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        fl;
        logic        lr;
        logic [31:0] la;
        logic        eig;
        logic        elg;
        logic        ece;
        logic [31:0] era;
        logic        est;
        logic        eiv;
        logic [31:0] eid;
        logic        eie;
        logic        elv;
        logic [31:0] eld;
        logic        ele;
    } vec_t;

    vec_t v[10];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic fl,
        input logic lr, input logic [31:0] la,
        input logic eig, input logic elg, input logic ece,
        input logic [31:0] era, input logic est,
        input logic eiv, input logic [31:0] eid, input logic eie,
        input logic elv, input logic [31:0] eld, input logic ele);
        vec_t r;
        r.ir = ir; r.ia = ia; r.fl = fl; r.lr = lr; r.la = la;
        r.eig = eig; r.elg = elg; r.ece = ece; r.era = era; r.est = est;
        r.eiv = eiv; r.eid = eid; r.eie = eie;
        r.elv = elv; r.eld = eld; r.ele = ele;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic fl, input logic lr,
                         input logic [31:0] la);
        if_req = ir; if_addr = ia; if_flush = fl;
        ls_req = lr; ls_addr = la;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        do_reset();

        // Rows applied in order from reset; prio evolution hand-tracked.
        v[0] = mk(1'b1, 32'h4, 1'b0, 1'b0, 32'h0,
                  1'b1, 1'b0, 1'b1, 32'h4, 1'b0,
                  1'b1, 32'h3401_0100, 1'b0, 1'b0, 32'h0, 1'b0);
        v[1] = mk(1'b1, 32'h8, 1'b0, 1'b1, 32'hC,
                  1'b0, 1'b1, 1'b1, 32'hC, 1'b1,
                  1'b0, 32'h0, 1'b0, 1'b1, rom_word(32'hC), 1'b0);
        v[2] = mk(1'b1, 32'h8, 1'b0, 1'b1, 32'hC,
                  1'b1, 1'b0, 1'b1, 32'h8, 1'b0,
                  1'b1, rom_word(32'h8), 1'b0, 1'b0, 32'h0, 1'b0);
        v[3] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h0008_0000,
                  1'b0, 1'b1, 1'b0, 32'h0, 1'b0,
                  1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        v[4] = mk(1'b1, 32'h6, 1'b0, 1'b0, 32'h0,
                  1'b1, 1'b0, 1'b0, 32'h0, 1'b0,
                  1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        v[5] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        // prio is LS here; flush row then proves prio returns to IF
        v[6] = mk(1'b1, 32'h10, 1'b1, 1'b1, 32'h14,
                  1'b0, 1'b1, 1'b1, 32'h14, 1'b0,
                  1'b0, 32'h0, 1'b0, 1'b1, rom_word(32'h14), 1'b0);
        v[7] = mk(1'b1, 32'h10, 1'b0, 1'b1, 32'h14,
                  1'b1, 1'b0, 1'b1, 32'h10, 1'b0,
                  1'b1, rom_word(32'h10), 1'b0, 1'b0, 32'h0, 1'b0);
        v[8] = mk(1'b1, 32'h20, 1'b1, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        v[9] = mk(1'b1, 32'h0007_FFFC, 1'b0, 1'b0, 32'h0,
                  1'b1, 1'b0, 1'b1, 32'h0007_FFFC, 1'b0,
                  1'b1, rom_word(32'h0007_FFFC), 1'b0,
                  1'b0, 32'h0, 1'b0);

        for (int i = 0; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
                chk("rst_if_rdata", if_rdata, 32'h0);
                chk("rst_ls_rvalid", {31'b0, ls_rvalid}, 32'h0);
                chk("rst_ls_err", {31'b0, ls_err}, 32'h0);
            end else begin
                chk($sformatf("v%0d_if_rvalid", i-1), {31'b0, if_rvalid}, {31'b0, v[i-1].eiv});
                chk($sformatf("v%0d_if_rdata", i-1), if_rdata, v[i-1].eid);
                chk($sformatf("v%0d_if_err", i-1), {31'b0, if_err}, {31'b0, v[i-1].eie});
                chk($sformatf("v%0d_ls_rvalid", i-1), {31'b0, ls_rvalid}, {31'b0, v[i-1].elv});
                chk($sformatf("v%0d_ls_rdata", i-1), ls_rdata, v[i-1].eld);
                chk($sformatf("v%0d_ls_err", i-1), {31'b0, ls_err}, {31'b0, v[i-1].ele});
            end
            if (i < 10) begin
                drive(v[i].ir, v[i].ia, v[i].fl, v[i].lr, v[i].la);
                #4;
                chk($sformatf("v%0d_if_gnt", i), {31'b0, if_gnt}, {31'b0, v[i].eig});
                chk($sformatf("v%0d_ls_gnt", i), {31'b0, ls_gnt}, {31'b0, v[i].elg});
                chk($sformatf("v%0d_rom_ce", i), {31'b0, rom_ce}, {31'b0, v[i].ece});
                chk($sformatf("v%0d_rom_addr", i), rom_addr, v[i].era);
                chk($sformatf("v%0d_stallreq", i), {31'b0, stallreq}, {31'b0, v[i].est});
            end else begin
                drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            end
        end

        // Continuous contention from reset: IF, LS, IF, LS, IF, LS
        do_reset();
        @(posedge clk);
        #1 drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h4);
        for (int k = 0; k < 6; k++) begin
            #4;
            chk($sformatf("rr%0d_if_gnt", k), {31'b0, if_gnt}, {31'b0, (k % 2) == 0});
            chk($sformatf("rr%0d_ls_gnt", k), {31'b0, ls_gnt}, {31'b0, (k % 2) == 1});
            chk($sformatf("rr%0d_stallreq", k), {31'b0, stallreq}, {31'b0, (k % 2) == 1});
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_if_rvalid", k), {31'b0, if_rvalid}, {31'b0, (k % 2) == 0});
            chk($sformatf("rr%0d_ls_rvalid", k), {31'b0, ls_rvalid}, {31'b0, (k % 2) == 1});
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Reset mid-cycle right after an IF grant; prio would be LS without it
        @(posedge clk);
        #1 drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        #2;
        chk("mrst_pre_if_gnt", {31'b0, if_gnt}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mrst_if_gnt", {31'b0, if_gnt}, 32'h0);
        chk("mrst_rom_ce", {31'b0, rom_ce}, 32'h0);
        drive(1'b1, 32'h4, 1'b0, 1'b1, 32'h8);
        #1;
        chk("mrst_both_if_gnt", {31'b0, if_gnt}, 32'h0);
        chk("mrst_both_ls_gnt", {31'b0, ls_gnt}, 32'h0);
        @(posedge clk);
        #1;
        chk("mrst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
        chk("mrst_if_rdata", if_rdata, 32'h0);
        #4 rst = 1'b0;
        #1;
        chk("post_rst_if_gnt", {31'b0, if_gnt}, 32'h1);
        chk("post_rst_ls_gnt", {31'b0, ls_gnt}, 32'h0);
        chk("post_rst_if_rvalid", {31'b0, if_rvalid}, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_rsp_if_rvalid", {31'b0, if_rvalid}, 32'h1);
        chk("post_rst_rsp_if_rdata", if_rdata, 32'h3401_0100);
        #4;
        chk("post_rst_next_ls_gnt", {31'b0, ls_gnt}, 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
